// File: rtl/regbank_arbiter.sv
// Two-client round-robin arbiter in front of a 1W/1R register bank: independent write
// and read grants each cycle, same-cycle write-to-read forwarding, one-cycle read response.
module regbank_arbiter #(
   parameter int DW = 8,
   parameter int AW = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      req_valid,
   input  logic [1:0]      req_we,
   input  logic [2*AW-1:0] req_addr,
   input  logic [2*DW-1:0] req_wdata,
   output logic [1:0]      req_ready,
   output logic [1:0]      rsp_valid,
   output logic [DW-1:0]   rsp_data,
   output logic            bank_ld,
   output logic [AW-1:0]   bank_addr_W,
   output logic [DW-1:0]   bank_in,
   output logic [AW-1:0]   bank_addr_R,
   input  logic [DW-1:0]   bank_out
);

   logic [1:0]    wcand, rcand, wgnt, rgnt;
   logic          wprio, rprio;
   logic          wany, rany, wsel, rsel;
   logic [AW-1:0] waddr, raddr;
   logic [DW-1:0] wdata;
   logic          fwd_hit;
   logic          rd_pend, rd_id, fwd;
   logic [DW-1:0] fwd_data;

   // Grants are suppressed while reset is held so nothing reaches the bank.
   always_comb begin
      wcand   = rst ? 2'b00 : (req_valid & req_we);
      rcand   = rst ? 2'b00 : (req_valid & ~req_we);
      wgnt    = (wcand == 2'b11) ? (wprio ? 2'b10 : 2'b01) : wcand;
      rgnt    = (rcand == 2'b11) ? (rprio ? 2'b10 : 2'b01) : rcand;
      wany    = |wgnt;
      rany    = |rgnt;
      wsel    = wgnt[1];
      rsel    = rgnt[1];
      waddr   = wsel ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
      raddr   = rsel ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
      wdata   = wsel ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
      fwd_hit = wany && rany && (waddr == raddr) && (raddr != '0);
   end

   assign req_ready   = wgnt | rgnt;
   assign bank_ld     = wany;
   assign bank_addr_W = wany ? waddr : '0;
   assign bank_in     = wany ? wdata : '0;
   assign bank_addr_R = rany ? raddr : '0;

   // The bank's registered output lags one cycle, so the forwarded value is held alongside it.
   always_ff @(posedge clk) begin
      if (rst) begin
         wprio    <= 1'b0;
         rprio    <= 1'b0;
         rd_pend  <= 1'b0;
         rd_id    <= 1'b0;
         fwd      <= 1'b0;
         fwd_data <= '0;
      end else begin
         if (wany) wprio <= ~wsel;
         if (rany) rprio <= ~rsel;
         rd_pend  <= rany;
         rd_id    <= rsel;
         fwd      <= fwd_hit;
         fwd_data <= fwd_hit ? wdata : '0;
      end
   end

   assign rsp_valid = (rd_pend && !rst) ? (rd_id ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_data  = (|rsp_valid) ? (fwd ? fwd_data : bank_out) : '0;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter: bank model, register-level reference model of the arbitration
// rules, and a scoreboard queue whose entries are popped by a separate response monitor.
module tb_regbank_arbiter;
   localparam int DW = 8;
   localparam int AW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      req_valid, req_we, req_ready, rsp_valid;
   logic [2*AW-1:0] req_addr;
   logic [2*DW-1:0] req_wdata;
   logic [DW-1:0]   rsp_data, bank_in, bank_out;
   logic            bank_ld;
   logic [AW-1:0]   bank_addr_W, bank_addr_R;
   logic            bank_init;

   regbank_arbiter #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .bank_ld(bank_ld), .bank_addr_W(bank_addr_W), .bank_in(bank_in),
      .bank_addr_R(bank_addr_R), .bank_out(bank_out)
   );

   always #5 clk = ~clk;

   // Register bank: register 0 reads as zero, output registered one cycle after the address.
   logic [DW-1:0] mem [0:3];
   always @(posedge clk) begin
      if (bank_init) begin
         for (int i = 0; i < 4; i++) mem[i] <= '0;
         bank_out <= '0;
      end else begin
         if (bank_ld && bank_addr_W != '0) mem[bank_addr_W] <= bank_in;
         bank_out <= (bank_addr_R == '0) ? '0 : mem[bank_addr_R];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int            due;
      logic [1:0]    id;
      logic [DW-1:0] data;
   } exp_t;
   exp_t q[$];

   logic          m_wprio, m_rprio;
   logic [DW-1:0] m_regs [0:3];
   logic [1:0]    fired;
   logic [1:0]    pend;

   function automatic logic [1:0] pick(input logic [1:0] cand, input logic prio);
      if (cand == 2'b11) return prio ? 2'b10 : 2'b01;
      return cand;
   endfunction

   // Reference model: evaluates one cycle's requests and checks the combinational outputs.
   task automatic checkOutput();
      logic [1:0]    wc, rc, wg, rg;
      int            wk, rk;
      logic [AW-1:0] wa, ra;
      logic [DW-1:0] wd, rd;
      exp_t          e;
      if (rst) begin
         check("rst_req_ready", 32'(req_ready), 32'd0);
         check("rst_bank_ld", 32'(bank_ld), 32'd0);
         check("rst_bank_addr_R", 32'(bank_addr_R), 32'd0);
         m_wprio = 1'b0;
         m_rprio = 1'b0;
         fired   = 2'b00;
         return;
      end
      wc = req_valid & req_we;
      rc = req_valid & ~req_we;
      wg = pick(wc, m_wprio);
      rg = pick(rc, m_rprio);
      check("req_ready", 32'(req_ready), 32'(wg | rg));
      check("bank_ld", 32'(bank_ld), 32'(|wg));
      wk = wg[1] ? 1 : 0;
      rk = rg[1] ? 1 : 0;
      wa = req_addr[wk*AW +: AW];
      wd = req_wdata[wk*DW +: DW];
      ra = req_addr[rk*AW +: AW];
      if (|wg) begin
         check("bank_addr_W", 32'(bank_addr_W), 32'(wa));
         check("bank_in", 32'(bank_in), 32'(wd));
         m_wprio = (wk == 0);
      end else begin
         check("bank_addr_W_idle", 32'(bank_addr_W), 32'd0);
         check("bank_in_idle", 32'(bank_in), 32'd0);
      end
      if (|rg) begin
         check("bank_addr_R", 32'(bank_addr_R), 32'(ra));
         if (ra == '0)                  rd = '0;
         else if ((|wg) && wa == ra)    rd = wd;
         else                           rd = m_regs[ra];
         e.due  = cyc + 1;
         e.id   = rg;
         e.data = rd;
         q.push_back(e);
         m_rprio = (rk == 0);
      end else begin
         check("bank_addr_R_idle", 32'(bank_addr_R), 32'd0);
      end
      if ((|wg) && wa != '0) m_regs[wa] = wd;
      fired = wg | rg;
   endtask

   // Response monitor: independent of stimulus, pops the scoreboard when a response is due.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
         check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         check("rst_rsp_data", 32'(rsp_data), 32'd0);
      end else if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         check("rsp_valid", 32'(rsp_valid), 32'(e.id));
         check("rsp_data", 32'(rsp_data), 32'(e.data));
      end else begin
         check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
         check("rsp_data_idle", 32'(rsp_data), 32'd0);
      end
   end

   task automatic applyStimulus(input int k, input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] data);
      req_valid[k]            = 1'b1;
      req_we[k]               = we;
      req_addr[k*AW +: AW]    = addr;
      req_wdata[k*DW +: DW]   = data;
      pend[k]                 = 1'b1;
   endtask

   task automatic step();
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         if (fired[k]) begin
            pend[k]      = 1'b0;
            req_valid[k] = 1'b0;
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      while (pend != 2'b00 && n < 10) begin
         step();
         n++;
      end
      check("drain_timeout", 32'(pend), 32'd0);
      pend      = 2'b00;
      req_valid = 2'b00;
   endtask

   initial begin
      rst       = 1'b1;
      bank_init = 1'b1;
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      pend      = '0;
      fired     = '0;
      m_wprio   = 1'b0;
      m_rprio   = 1'b0;
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
      step();
      step();
      rst       = 1'b0;
      bank_init = 1'b0;

      $display("[TB] basic write then read");
      applyStimulus(0, 1'b1, 2'd2, 8'hA5);
      drain();
      applyStimulus(1, 1'b0, 2'd2, 8'h00);
      drain();
      step();

      $display("[TB] preload with write contention and hold");
      applyStimulus(0, 1'b1, 2'd1, 8'h11);
      applyStimulus(1, 1'b1, 2'd3, 8'h33);
      drain();

      $display("[TB] read contention fairness");
      for (int r = 0; r < 2; r++) begin
         applyStimulus(0, 1'b0, 2'd1, 8'h00);
         applyStimulus(1, 1'b0, 2'd3, 8'h00);
         drain();
      end
      step();

      $display("[TB] parallel read/write forwarding");
      applyStimulus(0, 1'b1, 2'd3, 8'h5C);
      applyStimulus(1, 1'b0, 2'd3, 8'h00);
      drain();
      step();

      $display("[TB] register 0");
      applyStimulus(0, 1'b1, 2'd0, 8'hFF);
      applyStimulus(1, 1'b0, 2'd0, 8'h00);
      drain();
      applyStimulus(0, 1'b0, 2'd0, 8'h00);
      drain();
      step();

      $display("[TB] reset mid-operation");
      applyStimulus(0, 1'b0, 2'd1, 8'h00);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      applyStimulus(0, 1'b1, 2'd2, 8'h3C);
      applyStimulus(1, 1'b1, 2'd1, 8'hC3);
      drain();
      step();

      $display("[TB] randomized traffic");
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (!pend[k] && $urandom_range(3) != 0)
               applyStimulus(k, 1'($urandom_range(1)), AW'($urandom_range(3)),
                             DW'($urandom_range(255)));
         end
         step();
      end
      drain();
      repeat (3) step();
      check("missing_responses", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got %0d expected 0", 1);
      $fatal(1, "[TB] timeout");
   end

endmodule
